// File: rtl/bus_arbiter_rr_if.sv
// Serial bus signals between the masters, the slaves and the round-robin arbiter.
// slave  : the arbiter's view (it serves master requests and drives slave selects)
// master : the surrounding masters/slaves (or a testbench) driving the arbiter
interface bus_arbiter_rr_if #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3
);
  logic [NUM_MASTERS-1:0] m_request;
  logic [NUM_MASTERS-1:0] m_address_valid;
  logic [NUM_MASTERS-1:0] m_valid;
  logic [NUM_MASTERS-1:0] m_address;
  logic [NUM_MASTERS-1:0] m_data;
  logic [NUM_MASTERS-1:0] m_write_en;
  logic [NUM_MASTERS-1:0] m_grant;
  logic [NUM_MASTERS-1:0] m_ready;
  logic [NUM_MASTERS-1:0] m_data_out;
  logic [NUM_MASTERS-1:0] m_valid_in;
  logic [NUM_MASTERS-1:0] m_error;
  logic [NUM_SLAVES-1:0]  s_ready;
  logic [NUM_SLAVES-1:0]  s_hold;
  logic [NUM_SLAVES-1:0]  s_data_in;
  logic [NUM_SLAVES-1:0]  s_valid_out;
  logic [NUM_SLAVES-1:0]  s_address;
  logic [NUM_SLAVES-1:0]  s_data;
  logic [NUM_SLAVES-1:0]  s_valid;
  logic [NUM_SLAVES-1:0]  s_write_en;
  logic [NUM_SLAVES-1:0]  s_bus_ready;

  modport slave (
    input  m_request, m_address_valid, m_valid, m_address, m_data, m_write_en,
    input  s_ready, s_hold, s_data_in, s_valid_out,
    output m_grant, m_ready, m_data_out, m_valid_in, m_error,
    output s_address, s_data, s_valid, s_write_en, s_bus_ready
  );

  modport master (
    output m_request, m_address_valid, m_valid, m_address, m_data, m_write_en,
    output s_ready, s_hold, s_data_in, s_valid_out,
    input  m_grant, m_ready, m_data_out, m_valid_in, m_error,
    input  s_address, s_data, s_valid, s_write_en, s_bus_ready
  );
endinterface

// File: rtl/bus_arbiter_rr.sv
// Round-robin arbiter and single-path crossbar for serial bus masters/slaves,
// with split parking of masters whose slave asks to hold the bus.
//
// state      | meaning
// IDLE       | pick a resumable parked master, else round-robin a new request
// ADDR       | shift SEL_BITS serial slave-select bits (MSB first)
// CONNECT    | wait for selected slave ready (bounded by TIMEOUT)
// BUSY       | crossbar path granted master <-> selected slave
// SPLIT_PARK | connection dropped for one cycle, master parked
// RESUME     | reconnect parked master with its stored select
// ERROR      | one-cycle m_error pulse to the granted master
module bus_arbiter_rr #(
  parameter int NUM_MASTERS = 2,
  parameter int NUM_SLAVES  = 3,
  parameter int SEL_BITS    = 2,
  parameter int TIMEOUT     = 1023
) (
  input  logic             clk,
  input  logic             reset,
  bus_arbiter_rr_if.slave  bus,
  output logic [2:0]       state
);
  localparam int IW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
  localparam int WW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int BW = $clog2(SEL_BITS + 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_ADDR       = 3'd1,
    S_CONNECT    = 3'd2,
    S_BUSY       = 3'd3,
    S_SPLIT_PARK = 3'd4,
    S_RESUME     = 3'd5,
    S_ERROR      = 3'd6
  } state_t;

  state_t                 state_q, state_d;
  logic [IW-1:0]          rr_ptr_q, rr_ptr_d;
  logic [IW-1:0]          gnt_q, gnt_d;
  logic [SEL_BITS-1:0]    sel_q, sel_d;
  logic [BW-1:0]          bit_cnt_q, bit_cnt_d;
  logic [WW-1:0]          wait_cnt_q, wait_cnt_d;
  logic [NUM_MASTERS-1:0] split_valid_q, split_valid_d;
  logic [SEL_BITS-1:0]    split_sel_q [NUM_MASTERS];
  logic [SEL_BITS-1:0]    split_sel_d [NUM_MASTERS];

  logic [NUM_MASTERS-1:0] gnt_oh;
  logic [NUM_SLAVES-1:0]  sel_oh;
  logic                   sel_in_range, sel_ready, sel_held, busy;
  logic [NUM_MASTERS-1:0] resume_ok, new_req;
  logic                   resume_found, new_found;
  logic [IW-1:0]          resume_idx, new_idx;
  logic [SEL_BITS-1:0]    resume_sel;

  assign busy  = (state_q == S_BUSY);
  assign state = state_q;

  // Decode granted master / selected slave into one-hot masks; out-of-range
  // selects decode to all-zero, which doubles as the range check.
  always_comb begin
    gnt_oh = '0;
    for (int i = 0; i < NUM_MASTERS; i++) gnt_oh[i] = (gnt_q == IW'(i));
    sel_oh = '0;
    for (int k = 0; k < NUM_SLAVES; k++) sel_oh[k] = (sel_q == SEL_BITS'(k));
    sel_in_range = |sel_oh;
    sel_ready    = |(bus.s_ready & sel_oh);
  end

  // Split-table lookups: is the selected slave parked, which parked master can resume.
  always_comb begin
    sel_held     = 1'b0;
    resume_found = 1'b0;
    resume_idx   = '0;
    resume_sel   = '0;
    for (int p = 0; p < NUM_MASTERS; p++) begin
      if (split_valid_q[p] && split_sel_q[p] == sel_q) sel_held = 1'b1;
      resume_ok[p] = 1'b0;
      for (int k = 0; k < NUM_SLAVES; k++)
        if (split_valid_q[p] && bus.m_request[p] && split_sel_q[p] == SEL_BITS'(k) && bus.s_ready[k])
          resume_ok[p] = 1'b1;
    end
    for (int p = NUM_MASTERS - 1; p >= 0; p--) begin
      if (resume_ok[p]) begin
        resume_found = 1'b1;
        resume_idx   = IW'(p);
        resume_sel   = split_sel_q[p];
      end
    end
  end

  // Round-robin pick: lowest requester above rr_ptr, else lowest overall (wrap).
  always_comb begin
    new_req   = bus.m_request & bus.m_address_valid & ~split_valid_q;
    new_found = 1'b0;
    new_idx   = '0;
    for (int j = NUM_MASTERS - 1; j >= 0; j--)
      if (new_req[j]) begin
        new_found = 1'b1;
        new_idx   = IW'(j);
      end
    for (int j = NUM_MASTERS - 1; j >= 0; j--)
      if (new_req[j] && IW'(j) > rr_ptr_q) new_idx = IW'(j);
  end

  // Next-state logic; parked masters that drop their request lose their entry at once.
  always_comb begin
    state_d       = state_q;
    rr_ptr_d      = rr_ptr_q;
    gnt_d         = gnt_q;
    sel_d         = sel_q;
    bit_cnt_d     = bit_cnt_q;
    wait_cnt_d    = wait_cnt_q;
    split_valid_d = split_valid_q & bus.m_request;
    split_sel_d   = split_sel_q;
    unique case (state_q)
      S_IDLE: begin
        if (resume_found) begin
          state_d = S_RESUME;
          gnt_d   = resume_idx;
          sel_d   = resume_sel;
        end else if (new_found) begin
          state_d   = S_ADDR;
          gnt_d     = new_idx;
          sel_d     = '0;
          bit_cnt_d = '0;
        end
      end
      S_ADDR: begin
        if (|(bus.m_valid & gnt_oh)) begin
          sel_d     = SEL_BITS'({sel_q, |(bus.m_address & gnt_oh)});
          bit_cnt_d = bit_cnt_q + BW'(1);
          if (bit_cnt_q == BW'(SEL_BITS - 1)) begin
            state_d    = S_CONNECT;
            wait_cnt_d = '0;
          end
        end
      end
      S_CONNECT: begin
        if (!sel_in_range) begin
          state_d = S_ERROR;
        end else if (sel_ready && !sel_held) begin
          state_d = S_BUSY;
        end else begin
          // ERROR is taken on the edge where the counter reaches TIMEOUT,
          // i.e. after TIMEOUT waiting cycles.
          wait_cnt_d = wait_cnt_q + WW'(1);
          if (wait_cnt_d == WW'(TIMEOUT)) state_d = S_ERROR;
        end
      end
      S_BUSY: begin
        if (!(|(bus.m_request & gnt_oh))) begin
          state_d  = S_IDLE;
          rr_ptr_d = gnt_q;
        end else if (|(bus.s_hold & sel_oh) && |(bus.m_request & ~gnt_oh & ~split_valid_q)) begin
          state_d  = S_SPLIT_PARK;
          rr_ptr_d = gnt_q;
          for (int i = 0; i < NUM_MASTERS; i++)
            if (gnt_oh[i]) begin
              split_valid_d[i] = 1'b1;
              split_sel_d[i]   = sel_q;
            end
        end
      end
      S_SPLIT_PARK: state_d = S_IDLE;
      S_RESUME: begin
        state_d       = S_BUSY;
        split_valid_d = split_valid_d & ~gnt_oh;
      end
      S_ERROR: begin
        state_d  = S_IDLE;
        rr_ptr_d = gnt_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and bookkeeping registers, asynchronously cleared.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      rr_ptr_q      <= IW'(NUM_MASTERS - 1);
      gnt_q         <= '0;
      sel_q         <= '0;
      bit_cnt_q     <= '0;
      wait_cnt_q    <= '0;
      split_valid_q <= '0;
      for (int i = 0; i < NUM_MASTERS; i++) split_sel_q[i] <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      gnt_q         <= gnt_d;
      sel_q         <= sel_d;
      bit_cnt_q     <= bit_cnt_d;
      wait_cnt_q    <= wait_cnt_d;
      split_valid_q <= split_valid_d;
      split_sel_q   <= split_sel_d;
    end
  end

  // Grant/error outputs and crossbar; only BUSY carries a data path.
  always_comb begin
    bus.m_grant     = '0;
    bus.m_error     = '0;
    bus.m_ready     = '0;
    bus.m_data_out  = '0;
    bus.m_valid_in  = '0;
    bus.s_address   = '0;
    bus.s_data      = '0;
    bus.s_valid     = '0;
    bus.s_write_en  = '0;
    bus.s_bus_ready = '1;
    if (state_q == S_ADDR || state_q == S_CONNECT || state_q == S_RESUME || busy)
      bus.m_grant = gnt_oh;
    if (state_q == S_ERROR)
      bus.m_error = gnt_oh;
    if (busy) begin
      bus.s_address   = sel_oh & {NUM_SLAVES{|(bus.m_address & gnt_oh)}};
      bus.s_data      = sel_oh & {NUM_SLAVES{|(bus.m_data & gnt_oh)}};
      bus.s_valid     = sel_oh & {NUM_SLAVES{|(bus.m_valid & gnt_oh)}};
      bus.s_write_en  = sel_oh & {NUM_SLAVES{|(bus.m_write_en & gnt_oh)}};
      bus.m_ready     = gnt_oh & {NUM_MASTERS{|(bus.s_ready & sel_oh)}};
      bus.m_data_out  = gnt_oh & {NUM_MASTERS{|(bus.s_data_in & sel_oh)}};
      bus.m_valid_in  = gnt_oh & {NUM_MASTERS{|(bus.s_valid_out & sel_oh)}};
      bus.s_bus_ready = sel_oh;
    end
  end
endmodule

// File: tb/tb_bus_arbiter_rr.sv
// Directed bench for bus_arbiter_rr: a 2-master instance for the main scenarios
// and a 4-master instance for round-robin fairness.
module tb_bus_arbiter_rr;
  localparam int TIMEOUT = 1023;

  logic       clk = 1'b0;
  logic       rst0, rst4;
  logic [2:0] state0, state4;
  int         passed = 0;
  int         total  = 0;

  always #5 clk = ~clk;

  bus_arbiter_rr_if #(.NUM_MASTERS(2), .NUM_SLAVES(3)) bus0 ();
  bus_arbiter_rr_if #(.NUM_MASTERS(4), .NUM_SLAVES(3)) bus4 ();

  bus_arbiter_rr #(.NUM_MASTERS(2), .NUM_SLAVES(3), .SEL_BITS(2), .TIMEOUT(TIMEOUT)) u_dut0 (
    .clk(clk), .reset(rst0), .bus(bus0), .state(state0));
  bus_arbiter_rr #(.NUM_MASTERS(4), .NUM_SLAVES(3), .SEL_BITS(2), .TIMEOUT(TIMEOUT)) u_dut4 (
    .clk(clk), .reset(rst4), .bus(bus4), .state(state4));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs0();
    bus0.m_request = '0; bus0.m_address_valid = '0; bus0.m_valid = '0;
    bus0.m_address = '0; bus0.m_data = '0; bus0.m_write_en = '0;
    bus0.s_ready = '0; bus0.s_hold = '0; bus0.s_data_in = '0; bus0.s_valid_out = '0;
  endtask

  // Two serial select bits, MSB first, from master m.
  task automatic send_addr0(input int m, input logic b1, input logic b0);
    bus0.m_valid[m] = 1'b1; bus0.m_address[m] = b1; tick();
    bus0.m_address[m] = b0; tick();
    bus0.m_valid[m] = 1'b0; bus0.m_address[m] = 1'b0;
  endtask

  task automatic wait_state0(input logic [2:0] s, input int budget, output int cycles);
    cycles = 0;
    while (state0 !== s && cycles < budget) begin tick(); cycles++; end
  endtask

  task automatic test_reset();
    rst0 = 1'b1; rst4 = 1'b1;
    clear_inputs0();
    bus4.m_request = '0; bus4.m_address_valid = '0; bus4.m_valid = '0; bus4.m_address = '0;
    bus4.m_data = '0; bus4.m_write_en = '0; bus4.s_ready = '0; bus4.s_hold = '0;
    bus4.s_data_in = '0; bus4.s_valid_out = '0;
    #2;
    total++; if (state0 !== 3'd0) $display("FAIL reset_state: got %0d want 0", state0); else passed++;
    total++; if (bus0.s_bus_ready !== 3'b111) $display("FAIL reset_s_bus_ready: got %b want 111", bus0.s_bus_ready); else passed++;
    total++; if (state4 !== 3'd0) $display("FAIL reset_state4: got %0d want 0", state4); else passed++;
    bus0.m_request = 2'b11; bus0.m_address_valid = 2'b11; bus0.s_ready = 3'b111;
    tick();
    total++; if (state0 !== 3'd0) $display("FAIL reset_held_state: got %0d want 0", state0); else passed++;
    total++; if (bus0.m_grant !== 2'b00) $display("FAIL reset_held_grant: got %b want 00", bus0.m_grant); else passed++;
    clear_inputs0();
    rst0 = 1'b0; rst4 = 1'b0;
    tick();
  endtask

  task automatic test_basic();
    bus0.m_request = 2'b11; bus0.m_address_valid = 2'b11; bus0.s_ready = 3'b111;
    tick();
    total++; if (state0 !== 3'd1) $display("FAIL basic_addr_state: got %0d want 1", state0); else passed++;
    total++; if (bus0.m_grant !== 2'b01) $display("FAIL basic_first_grant: got %b want 01", bus0.m_grant); else passed++;
    bus0.m_valid[0] = 1'b1; bus0.m_address[0] = 1'b0; #1;
    total++; if (bus0.s_valid !== 3'b000) $display("FAIL basic_addr_s_valid: got %b want 000", bus0.s_valid); else passed++;
    tick();
    total++; if (state0 !== 3'd1) $display("FAIL basic_addr_bit1_state: got %0d want 1", state0); else passed++;
    bus0.m_address[0] = 1'b1; tick();
    bus0.m_valid[0] = 1'b0; bus0.m_address[0] = 1'b0;
    total++; if (state0 !== 3'd2) $display("FAIL basic_connect_state: got %0d want 2", state0); else passed++;
    tick();
    total++; if (state0 !== 3'd3) $display("FAIL basic_busy_state: got %0d want 3", state0); else passed++;
    bus0.m_address = 2'b11; bus0.m_data = 2'b11; bus0.m_valid = 2'b11; bus0.m_write_en = 2'b11;
    bus0.s_data_in = 3'b111; bus0.s_valid_out = 3'b111;
    #1;
    total++; if (bus0.s_address !== 3'b010) $display("FAIL basic_s_address: got %b want 010", bus0.s_address); else passed++;
    total++; if (bus0.s_data !== 3'b010) $display("FAIL basic_s_data: got %b want 010", bus0.s_data); else passed++;
    total++; if (bus0.s_write_en !== 3'b010) $display("FAIL basic_s_write_en: got %b want 010", bus0.s_write_en); else passed++;
    total++; if (bus0.m_data_out !== 2'b01) $display("FAIL basic_m_data_out: got %b want 01", bus0.m_data_out); else passed++;
    total++; if (bus0.m_valid_in !== 2'b01) $display("FAIL basic_m_valid_in: got %b want 01", bus0.m_valid_in); else passed++;
    total++; if (bus0.m_ready !== 2'b01) $display("FAIL basic_m_ready: got %b want 01", bus0.m_ready); else passed++;
    total++; if (bus0.s_bus_ready !== 3'b010) $display("FAIL basic_s_bus_ready: got %b want 010", bus0.s_bus_ready); else passed++;
    bus0.m_address = '0; bus0.m_data = '0; bus0.m_valid = '0; bus0.m_write_en = '0;
    bus0.s_data_in = '0; bus0.s_valid_out = '0;
    bus0.m_request[0] = 1'b0; bus0.m_address_valid[0] = 1'b0;
    tick();
    total++; if (state0 !== 3'd0) $display("FAIL basic_release_state: got %0d want 0", state0); else passed++;
    tick();
    total++; if (bus0.m_grant !== 2'b10) $display("FAIL basic_second_grant: got %b want 10", bus0.m_grant); else passed++;
    send_addr0(1, 1'b0, 1'b1);
    tick();
    total++; if (state0 !== 3'd3) $display("FAIL basic_m1_busy: got %0d want 3", state0); else passed++;
    total++; if (bus0.s_bus_ready !== 3'b010) $display("FAIL basic_m1_s_bus_ready: got %b want 010", bus0.s_bus_ready); else passed++;
    bus0.m_request = 2'b00; bus0.m_address_valid = 2'b00;
    tick();
    total++; if (state0 !== 3'd0) $display("FAIL basic_m1_release: got %0d want 0", state0); else passed++;
    clear_inputs0();
  endtask

  task automatic test_split();
    bus0.m_request = 2'b01; bus0.m_address_valid = 2'b01; bus0.s_ready = 3'b100;
    tick();
    send_addr0(0, 1'b1, 1'b0);
    tick();
    total++; if (state0 !== 3'd3) $display("FAIL split_m0_busy: got %0d want 3", state0); else passed++;
    bus0.s_hold = 3'b100; bus0.s_ready = 3'b001;
    bus0.m_request = 2'b11; bus0.m_address_valid = 2'b11;
    tick();
    total++; if (state0 !== 3'd4) $display("FAIL split_park_state: got %0d want 4", state0); else passed++;
    total++; if (bus0.s_bus_ready !== 3'b111) $display("FAIL split_park_dropped: got %b want 111", bus0.s_bus_ready); else passed++;
    tick();
    tick();
    total++; if (bus0.m_grant !== 2'b10) $display("FAIL split_m1_grant: got %b want 10", bus0.m_grant); else passed++;
    send_addr0(1, 1'b0, 1'b0);
    tick();
    total++; if (state0 !== 3'd3) $display("FAIL split_m1_busy: got %0d want 3", state0); else passed++;
    total++; if (bus0.s_bus_ready !== 3'b001) $display("FAIL split_m1_slave0: got %b want 001", bus0.s_bus_ready); else passed++;
    bus0.s_hold = 3'b000; bus0.s_ready = 3'b101;
    bus0.m_request = 2'b01; bus0.m_address_valid = 2'b01;
    tick();
    tick();
    total++; if (state0 !== 3'd5) $display("FAIL split_resume_state: got %0d want 5", state0); else passed++;
    total++; if (bus0.m_grant !== 2'b01) $display("FAIL split_resume_grant: got %b want 01", bus0.m_grant); else passed++;
    tick();
    total++; if (state0 !== 3'd3) $display("FAIL split_resumed_busy: got %0d want 3", state0); else passed++;
    total++; if (bus0.s_bus_ready !== 3'b100) $display("FAIL split_resumed_slave2: got %b want 100", bus0.s_bus_ready); else passed++;
    bus0.m_request = 2'b00; bus0.m_address_valid = 2'b00;
    tick();
    clear_inputs0();
  endtask

  task automatic test_parked_slave_blocks();
    int cyc;
    bus0.m_request = 2'b01; bus0.m_address_valid = 2'b01; bus0.s_ready = 3'b100;
    tick();
    send_addr0(0, 1'b1, 1'b0);
    tick();
    bus0.s_hold = 3'b100; bus0.s_ready = 3'b000;
    bus0.m_request = 2'b11; bus0.m_address_valid = 2'b11;
    tick(); tick(); tick();
    total++; if (bus0.m_grant !== 2'b10) $display("FAIL held_m1_grant: got %b want 10", bus0.m_grant); else passed++;
    send_addr0(1, 1'b1, 1'b0);
    bus0.s_ready = 3'b100;
    for (int i = 0; i < 4; i++) tick();
    total++; if (state0 !== 3'd2) $display("FAIL held_waits_connect: got %0d want 2", state0); else passed++;
    wait_state0(3'd6, TIMEOUT + 10, cyc);
    total++; if (state0 !== 3'd6) $display("FAIL held_timeout_error: got %0d want 6", state0); else passed++;
    total++; if (bus0.m_error !== 2'b10) $display("FAIL held_m_error: got %b want 10", bus0.m_error); else passed++;
    tick();
    total++; if (bus0.m_error !== 2'b00) $display("FAIL held_error_one_cycle: got %b want 00", bus0.m_error); else passed++;
    tick();
    total++; if (state0 !== 3'd5) $display("FAIL held_resume_priority: got %0d want 5", state0); else passed++;
    bus0.s_hold = 3'b000; bus0.m_request = 2'b00; bus0.m_address_valid = 2'b00;
    tick(); tick();
    total++; if (state0 !== 3'd0) $display("FAIL held_final_idle: got %0d want 0", state0); else passed++;
    clear_inputs0();
  endtask

  task automatic test_addr_error();
    bus0.m_request = 2'b10; bus0.m_address_valid = 2'b10; bus0.s_ready = 3'b111;
    tick();
    total++; if (bus0.m_grant !== 2'b10) $display("FAIL err_grant: got %b want 10", bus0.m_grant); else passed++;
    tick();
    total++; if (state0 !== 3'd1) $display("FAIL err_addr_stall: got %0d want 1", state0); else passed++;
    send_addr0(1, 1'b1, 1'b1);
    tick();
    total++; if (state0 !== 3'd6) $display("FAIL err_state: got %0d want 6", state0); else passed++;
    total++; if (bus0.m_error !== 2'b10) $display("FAIL err_m_error: got %b want 10", bus0.m_error); else passed++;
    bus0.m_request = 2'b00; bus0.m_address_valid = 2'b00;
    tick();
    total++; if (state0 !== 3'd0) $display("FAIL err_back_idle: got %0d want 0", state0); else passed++;
    total++; if (bus0.m_error !== 2'b00) $display("FAIL err_pulse_end: got %b want 00", bus0.m_error); else passed++;
    clear_inputs0();
  endtask

  task automatic test_timeout();
    int cyc;
    bus0.m_request = 2'b01; bus0.m_address_valid = 2'b01; bus0.s_ready = 3'b000;
    tick();
    send_addr0(0, 1'b0, 1'b0);
    total++; if (state0 !== 3'd2) $display("FAIL to_connect: got %0d want 2", state0); else passed++;
    wait_state0(3'd6, TIMEOUT + 20, cyc);
    total++; if (cyc !== TIMEOUT) $display("FAIL to_cycles: got %0d want %0d", cyc, TIMEOUT); else passed++;
    total++; if (bus0.m_error !== 2'b01) $display("FAIL to_m_error: got %b want 01", bus0.m_error); else passed++;
    bus0.m_request = 2'b00; bus0.m_address_valid = 2'b00;
    tick();
    total++; if (state0 !== 3'd0) $display("FAIL to_idle: got %0d want 0", state0); else passed++;
    clear_inputs0();
  endtask

  task automatic test_reset_mid_busy();
    bus0.m_request = 2'b10; bus0.m_address_valid = 2'b10; bus0.s_ready = 3'b010;
    tick();
    send_addr0(1, 1'b0, 1'b1);
    tick();
    bus0.m_valid = 2'b10; bus0.m_data = 2'b10; bus0.s_valid_out = 3'b010;
    #1;
    total++; if (bus0.s_valid !== 3'b010) $display("FAIL rst_pre_busy: got %b want 010", bus0.s_valid); else passed++;
    rst0 = 1'b1;
    #1;
    total++; if (state0 !== 3'd0) $display("FAIL rst_mid_state: got %0d want 0", state0); else passed++;
    total++; if (bus0.s_valid !== 3'b000) $display("FAIL rst_mid_s_valid: got %b want 000", bus0.s_valid); else passed++;
    total++; if (bus0.s_data !== 3'b000) $display("FAIL rst_mid_s_data: got %b want 000", bus0.s_data); else passed++;
    total++; if (bus0.m_grant !== 2'b00) $display("FAIL rst_mid_grant: got %b want 00", bus0.m_grant); else passed++;
    total++; if (bus0.m_valid_in !== 2'b00) $display("FAIL rst_mid_m_valid_in: got %b want 00", bus0.m_valid_in); else passed++;
    total++; if (bus0.s_bus_ready !== 3'b111) $display("FAIL rst_mid_s_bus_ready: got %b want 111", bus0.s_bus_ready); else passed++;
    tick();
    total++; if (bus0.m_error !== 2'b00) $display("FAIL rst_mid_no_error: got %b want 00", bus0.m_error); else passed++;
    clear_inputs0();
    rst0 = 1'b0;
    tick();
  endtask

  task automatic test_rr4();
    int cnt;
    int exp;
    bus4.m_request = 4'hF; bus4.m_address_valid = 4'hF; bus4.m_valid = 4'hF;
    bus4.m_address = 4'h0; bus4.s_ready = 3'b001;
    for (int n = 0; n < 5; n++) begin
      exp = n % 4;
      cnt = 0;
      while (state4 !== 3'd1 && cnt < 8) begin tick(); cnt++; end
      total++; if (bus4.m_grant !== 4'(1 << exp)) $display("FAIL rr4_grant_%0d: got %b want %b", n, bus4.m_grant, 4'(1 << exp)); else passed++;
      cnt = 0;
      while (state4 !== 3'd3 && cnt < 8) begin tick(); cnt++; end
      total++; if (state4 !== 3'd3) $display("FAIL rr4_busy_%0d: got %0d want 3", n, state4); else passed++;
      bus4.m_request[exp] = 1'b0;
      tick();
      bus4.m_request[exp] = 1'b1;
    end
    bus4.m_request = '0; bus4.m_address_valid = '0; bus4.m_valid = '0; bus4.s_ready = '0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_split();
    test_parked_slave_blocks();
    test_addr_error();
    test_timeout();
    test_reset_mid_busy();
    test_rr4();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/bus_arbiter_rr.md
BUS_ARBITER_RR -- requirements
Module: bus_arbiter_rr

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 2, number of serial bus masters (2..8).
REQ-002 SHALL have parameter NUM_SLAVES, default 3, number of slaves (2..2**SEL_BITS).
REQ-003 SHALL have parameter SEL_BITS, default 2, number of serial slave-select address bits, MSB first.
REQ-004 SHALL have parameter TIMEOUT, default 1023, max CONNECT wait cycles for slave ready.
REQ-005 SHALL have port clk, input, 1, the only clock; all logic is rising-edge.
REQ-006 SHALL have port reset, input, 1; reset is asynchronous and active-high.
REQ-007 SHALL have ports m_request, m_address_valid, m_valid, m_address, m_data, m_write_en, each input, NUM_MASTERS, one bit per master.
REQ-008 SHALL have ports m_grant, m_ready, m_data_out, m_valid_in, m_error, each output, NUM_MASTERS, one bit per master.
REQ-009 SHALL have ports s_ready, s_hold, s_data_in, s_valid_out, each input, NUM_SLAVES, one bit per slave.
REQ-010 SHALL have ports s_address, s_data, s_valid, s_write_en, s_bus_ready, each output, NUM_SLAVES, one bit per slave.
REQ-011 SHALL have port state, output, 3, current FSM state encoding.

Function
REQ-012 FSM states: IDLE=0, ADDR=1, CONNECT=2, BUSY=3, SPLIT_PARK=4, RESUME=5, ERROR=6.
REQ-013 IDLE: among masters with m_request&m_address_valid, select by round-robin starting at rr_ptr+1 (mod NUM_MASTERS); go to ADDR next cycle, m_grant one-hot for selected master.
REQ-014 Parked masters (split table) take priority over new requests when their slave's s_ready=1; IDLE then goes to RESUME.
REQ-015 ADDR: on each cycle with granted m_valid=1, shift m_address into sel register; after SEL_BITS bits go to CONNECT; cycles with m_valid=0 stall without shifting.
REQ-016 s_valid SHALL be held 0 during ADDR.
REQ-017 CONNECT: sel>=NUM_SLAVES -> ERROR; s_ready[sel]=1 -> BUSY with crossbar path enabled; else wait counter increments; counter==TIMEOUT -> ERROR.
REQ-018 ERROR: pulse m_error[granted]=1 for exactly one cycle, then IDLE; rr_ptr advances past that master.
REQ-019 BUSY: crossbar routes m_address/m_data/m_valid/m_write_en of granted master to slave sel; s_data_in/s_valid_out/s_ready of slave sel to that master's m_data_out/m_valid_in/m_ready; all unselected outputs 0.
REQ-020 s_bus_ready[k] SHALL be 1 unless a slave other than k is connected.
REQ-021 BUSY: m_request[granted] falling -> IDLE, rr_ptr <= granted index.
REQ-022 BUSY: s_hold[sel]=1 and any other master requesting -> SPLIT_PARK; store {master, sel} in split table, one entry per master.
REQ-023 SPLIT_PARK: drop connection for one cycle, then IDLE; parked master keeps m_grant=0 and its request is ignored for new arbitration until resumed.
REQ-024 RESUME: reconnect lowest-index parked master whose slave s_ready=1 directly to BUSY with stored sel, no ADDR phase; clear its table entry.
REQ-025 A slave held by a parked master SHALL not be granted to another master; such a request waits in CONNECT (timeout applies).
REQ-026 Parked master deasserting m_request SHALL clear its split entry in the same cycle.
REQ-027 Simultaneous request and s_hold in same cycle: split rule (REQ-022) wins over continuation.
REQ-028 Wait counter width SHALL be $clog2(TIMEOUT+1); clears on entering CONNECT.
REQ-029 rr_ptr wraps from NUM_MASTERS-1 to 0.

Reset
REQ-030 Reset asserted at any time SHALL, without a clock edge: state=IDLE, rr_ptr=NUM_MASTERS-1, split table empty, counter 0, sel 0.
REQ-031 During reset: m_grant, m_ready, m_data_out, m_valid_in, m_error, s_address, s_data, s_valid, s_write_en all 0; s_bus_ready all 1.
REQ-032 Reset mid-BUSY drops the connection immediately; no m_error pulse.

Verification
REQ-033 M0 and M1 request together from reset, both addr bits "01" -> M0 granted first, connects to slave 1; after M0 releases, M1 granted.
REQ-034 M0 in BUSY on slave 2, s_hold[2]=1, M1 requests slave 0 -> SPLIT_PARK, M1 served; s_ready[2]=1 later -> RESUME, M0 BUSY on slave 2 without ADDR.
REQ-035 Address "11" with NUM_SLAVES=3 -> ERROR, m_error[master]=1 one cycle, state back to IDLE.
REQ-036 s_ready[0]=0 for TIMEOUT cycles in CONNECT -> m_error pulse at cycle TIMEOUT, IDLE.
REQ-037 Reset asserted mid-BUSY between clock edges -> all outputs at reset values before next edge.
REQ-038 NUM_MASTERS=4, all requesting continuously with short transfers -> grants in order 0,1,2,3,0.
